// File: rtl/up_pkg.sv
// Shared opcode values, FSM state encoding and return-stack sizing for the
// up_seq_controller sequencer.
package up_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_JMP  = 4'd4;
    localparam logic [3:0] OP_JZ   = 4'd5;
    localparam logic [3:0] OP_OUT  = 4'd6;
    localparam logic [3:0] OP_IN   = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd8;
    localparam logic [3:0] OP_CALL = 4'd9;
    localparam logic [3:0] OP_RET  = 4'd10;

    localparam int STACK_DEPTH = 4;
    // The stack pointer needs one extra bit so that "full" (== STACK_DEPTH)
    // can be told apart from "empty".
    localparam int SP_IDX_W    = $clog2(STACK_DEPTH);
    localparam int SP_W        = SP_IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/up_imem.sv
// Program memory: synchronous write port, combinational read port.
// Contents are deliberately not reset so a program survives nRst.
module up_imem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W+3:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W+3:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W+3:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/up_seq_controller.sv
// Accumulator sequencer: every instruction is one FETCH cycle plus one EXEC cycle.
// Define UP_CALL_STACK_EN to add a 4-entry return stack with CALL (9) and RET (10).
module up_seq_controller
    import up_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W+3:0] prog_data,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        dbg_state
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n, pc_inc, target;
    logic [DATA_W-1:0] acc, acc_n, out_q, out_n, opnd, add_res, sub_res;
    logic              zero, zero_n, outv_q, outv_n, mem_we;
    logic [DATA_W+3:0] ir, ir_n, rdata;
    logic [3:0]        opc;

    up_imem #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (rdata)
    );

    assign opc     = ir[DATA_W+3:DATA_W];
    assign opnd    = ir[DATA_W-1:0];
    assign target  = opnd[ADDR_W-1:0];
    assign pc_inc  = pc_q + 1'b1;
    assign add_res = acc + opnd;
    assign sub_res = acc - opnd;

`ifdef UP_CALL_STACK_EN
    logic [SP_W-1:0]     sp, sp_n;
    logic [SP_IDX_W-1:0] sp_top;
    logic [ADDR_W-1:0]   stack [STACK_DEPTH];
    logic                push;

    assign sp_top = sp[SP_IDX_W-1:0] - 1'b1;

    always_ff @(posedge clk) begin
        if (push) begin
            stack[sp[SP_IDX_W-1:0]] <= pc_inc;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sp <= '0;
        end else begin
            sp <= sp_n;
        end
    end
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state  <= ST_IDLE;
            pc_q   <= '0;
            acc    <= '0;
            zero   <= 1'b0;
            ir     <= '0;
            out_q  <= '0;
            outv_q <= 1'b0;
        end else begin
            state  <= state_n;
            pc_q   <= pc_n;
            acc    <= acc_n;
            zero   <= zero_n;
            ir     <= ir_n;
            out_q  <= out_n;
            outv_q <= outv_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        acc_n   = acc;
        zero_n  = zero;
        ir_n    = ir;
        out_n   = out_q;
        outv_n  = 1'b0;
        mem_we  = 1'b0;
`ifdef UP_CALL_STACK_EN
        sp_n    = sp;
        push    = 1'b0;
`endif
        case (state)
            // Writes and start share an edge: the fetch that follows reads the new word.
            ST_IDLE, ST_HALT: begin
                mem_we = prog_we;
                if (start) begin
                    state_n = ST_FETCH;
                    pc_n    = '0;
                    zero_n  = 1'b0;
`ifdef UP_CALL_STACK_EN
                    sp_n    = '0;
`endif
                end
            end
            ST_FETCH: begin
                ir_n    = rdata;
                state_n = ST_EXEC;
            end
            ST_EXEC: begin
                state_n = ST_FETCH;
                pc_n    = pc_inc;
                case (opc)
                    OP_LDI: begin
                        acc_n  = opnd;
                        zero_n = (opnd == '0);
                    end
                    OP_ADD: begin
                        acc_n  = add_res;
                        zero_n = (add_res == '0);
                    end
                    OP_SUB: begin
                        acc_n  = sub_res;
                        zero_n = (sub_res == '0);
                    end
                    OP_JMP: pc_n = target;
                    OP_JZ: begin
                        if (zero) begin
                            pc_n = target;
                        end
                    end
                    // out_valid is a registered pulse: high for the one cycle after OUT executes.
                    OP_OUT: begin
                        out_n  = acc;
                        outv_n = 1'b1;
                    end
                    OP_IN: begin
                        acc_n  = in_data;
                        zero_n = (in_data == '0);
                    end
                    OP_HALT: begin
                        state_n = ST_HALT;
                        pc_n    = pc_q;
                    end
`ifdef UP_CALL_STACK_EN
                    OP_CALL: begin
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            state_n = ST_HALT;
                            pc_n    = pc_q;
                        end else begin
                            push = 1'b1;
                            sp_n = sp + 1'b1;
                            pc_n = target;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            state_n = ST_HALT;
                            pc_n    = pc_q;
                        end else begin
                            sp_n = sp - 1'b1;
                            pc_n = stack[sp_top];
                        end
                    end
`endif
                    default: ;
                endcase
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign out_data  = out_q;
    assign out_valid = outv_q;
    assign busy      = (state == ST_FETCH) || (state == ST_EXEC);
    assign halted    = (state == ST_HALT);
    assign pc        = pc_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_up_seq_controller.sv
// Bench for up_seq_controller: an instruction-level reference model checked every
// cycle, plus directed programs with hand-computed results.
module tb_up_seq_controller;
    import up_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int IW    = DW + 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic          start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          halted;
    logic [AW-1:0] pc;
    logic [1:0]    dbg_state;

    up_seq_controller #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .halted    (halted),
        .pc        (pc),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] enc(input int op, input int v);
        logic [3:0]    o;
        logic [DW-1:0] d;
        o = op[3:0];
        d = v[DW-1:0];
        return {o, d};
    endfunction

    // Reference model: architectural state stepped one instruction per two clocks.
    logic [IW-1:0] m_mem [DEPTH];
    logic [IW-1:0] m_ir;
    int m_mode;      // 0 idle, 1 running, 2 halted
    bit m_fetched;
    int m_pc, m_acc, m_out;
    bit m_zero, m_outv;
    int m_stk[$];

    function automatic void model_exec();
        int op, v, nxt;
        op  = int'(m_ir[IW-1:DW]);
        v   = int'(m_ir[DW-1:0]);
        nxt = (m_pc + 1) % DEPTH;
        case (op)
            1: begin m_acc = v; m_zero = (m_acc == 0); end
            2: begin m_acc = (m_acc + v) % 256; m_zero = (m_acc == 0); end
            3: begin m_acc = (m_acc - v + 256) % 256; m_zero = (m_acc == 0); end
            4: nxt = v % DEPTH;
            5: if (m_zero) nxt = v % DEPTH;
            6: begin m_out = m_acc; m_outv = 1'b1; end
            7: begin m_acc = int'(in_data); m_zero = (m_acc == 0); end
            8: begin m_mode = 2; nxt = m_pc; end
`ifdef UP_CALL_STACK_EN
            9: begin
                if (m_stk.size() == 4) begin m_mode = 2; nxt = m_pc; end
                else begin m_stk.push_back(nxt); nxt = v % DEPTH; end
            end
            10: begin
                if (m_stk.size() == 0) begin m_mode = 2; nxt = m_pc; end
                else nxt = m_stk.pop_back();
            end
`endif
            default: ;
        endcase
        m_pc = nxt;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge nRst);
            if (!nRst) begin
                m_mode = 0; m_fetched = 1'b0; m_pc = 0; m_acc = 0; m_out = 0;
                m_zero = 1'b0; m_outv = 1'b0; m_stk.delete();
            end else begin
                m_outv = 1'b0;
                if (m_mode != 1) begin
                    if (prog_we) m_mem[prog_addr] = prog_data;
                    if (start) begin
                        m_mode = 1; m_fetched = 1'b0; m_pc = 0; m_zero = 1'b0; m_stk.delete();
                    end
                end else if (!m_fetched) begin
                    m_ir = m_mem[m_pc];
                    m_fetched = 1'b1;
                end else begin
                    m_fetched = 1'b0;
                    model_exec();
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (nRst) begin
                chk("cyc_pc",        32'(pc),        32'(m_pc));
                chk("cyc_out_data",  32'(out_data),  32'(m_out));
                chk("cyc_out_valid", 32'(out_valid), 32'(m_outv));
                chk("cyc_busy",      32'(busy),      32'(m_mode == 1));
                chk("cyc_halted",    32'(halted),    32'(m_mode == 2));
                if (out_valid) pulse_cnt++;
            end
        end
    end

    logic [IW-1:0] prog [DEPTH];

    task automatic fill_halt();
        for (int i = 0; i < DEPTH; i++) prog[i] = enc(8, 0);
    endtask

    task automatic load_prog();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = AW'(i);
            prog_data = prog[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic kick(input bit w, input logic [AW-1:0] a, input logic [IW-1:0] d);
        @(negedge clk);
        start     = 1'b1;
        prog_we   = w;
        prog_addr = a;
        prog_data = d;
        pulse_cnt = 0;
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic wait_halt(input int max, output int cycles);
        cycles = 0;
        while (!halted && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
        if (!halted) begin
            n_assert++;
            n_fail++;
            $display("FAIL halt_timeout: halted=%0b after %0d cycles, required 1", halted, cycles);
        end
    endtask

    task automatic load_basic();
        fill_halt();
        prog[0] = enc(1, 5);
        prog[1] = enc(2, 3);
        prog[2] = enc(6, 0);
        prog[3] = enc(8, 0);
        load_prog();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pc",        32'(pc),        0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_halted",    32'(halted),    0);
        #2 nRst = 1'b1;

        // LDI 5, ADD 3, OUT, HALT: halted 8 cycles after start
        load_basic();
        kick(1'b0, '0, '0);
        wait_halt(40, cyc);
        chk("basic_cycles", 32'(cyc),       8);
        chk("basic_out",    32'(out_data),  8);
        chk("basic_pc",     32'(pc),        3);
        chk("basic_pulses", 32'(pulse_cnt), 1);
        chk("basic_halted", 32'(halted),    1);

        // countdown loop: one OUT of 0
        fill_halt();
        prog[0] = enc(1, 2);
        prog[1] = enc(3, 1);
        prog[2] = enc(5, 4);
        prog[3] = enc(4, 1);
        prog[4] = enc(6, 0);
        prog[5] = enc(8, 0);
        load_prog();
        kick(1'b0, '0, '0);
        wait_halt(80, cyc);
        chk("loop_out",    32'(out_data),  0);
        chk("loop_pulses", 32'(pulse_cnt), 1);
        chk("loop_pc",     32'(pc),        5);

        // 250 + 10 wraps to 4 and leaves zero clear (JZ not taken)
        fill_halt();
        prog[0] = enc(1, 250);
        prog[1] = enc(2, 10);
        prog[2] = enc(5, 5);
        prog[3] = enc(6, 0);
        prog[4] = enc(8, 0);
        load_prog();
        kick(1'b0, '0, '0);
        wait_halt(40, cyc);
        chk("wrap_out",    32'(out_data),  4);
        chk("wrap_pulses", 32'(pulse_cnt), 1);
        chk("wrap_pc",     32'(pc),        4);

        // pc wraps from 15 to 0 after reaching the top of memory
        fill_halt();
        prog[0]  = enc(5, 3);
        prog[1]  = enc(1, 0);
        prog[2]  = enc(4, 14);
        prog[14] = enc(6, 0);
        prog[15] = enc(0, 0);
        load_prog();
        kick(1'b0, '0, '0);
        wait_halt(60, cyc);
        chk("pcwrap_out", 32'(out_data), 0);
        chk("pcwrap_pc",  32'(pc),       3);

        // IN then SUB to zero, JZ taken, ADD 0x3C
        in_data = 8'hA5;
        fill_halt();
        prog[0] = enc(7, 0);
        prog[1] = enc(3, 8'hA5);
        prog[2] = enc(5, 5);
        prog[3] = enc(6, 0);
        prog[5] = enc(2, 8'h3C);
        prog[6] = enc(6, 0);
        load_prog();
        kick(1'b0, '0, '0);
        wait_halt(60, cyc);
        chk("in_out",    32'(out_data),  8'h3C);
        chk("in_pc",     32'(pc),        7);
        chk("in_pulses", 32'(pulse_cnt), 1);

        // unlisted opcodes behave as NOP
        fill_halt();
        prog[0] = enc(1, 9);
        prog[1] = enc(15, 8'hFF);
        prog[2] = enc(11, 3);
        prog[3] = enc(6, 0);
        load_prog();
        kick(1'b0, '0, '0);
        wait_halt(40, cyc);
        chk("nop_out", 32'(out_data), 9);
        chk("nop_pc",  32'(pc),       4);

        // reset during EXEC of ADD, then restart from intact memory
        load_basic();
        kick(1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("mid_state", 32'(dbg_state), 32'(ST_EXEC));
        chk("mid_pc",    32'(pc),        1);
        #2 nRst = 1'b0;
        #1;
        chk("arst_pc",        32'(pc),        0);
        chk("arst_out_data",  32'(out_data),  0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_busy",      32'(busy),      0);
        chk("arst_halted",    32'(halted),    0);
        @(negedge clk);
        chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
        #2 nRst = 1'b1;
        kick(1'b0, '0, '0);
        wait_halt(40, cyc);
        chk("rerun_cycles", 32'(cyc),       8);
        chk("rerun_out",    32'(out_data),  8);
        chk("rerun_pc",     32'(pc),        3);
        chk("rerun_pulses", 32'(pulse_cnt), 1);

        // writes while busy must be dropped
        kick(1'b0, '0, '0);
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = enc(2, 100);
        @(negedge clk);
        prog_addr = 4'd3;
        prog_data = enc(0, 0);
        @(negedge clk);
        prog_we = 1'b0;
        wait_halt(40, cyc);
        chk("busywe_out", 32'(out_data), 8);
        chk("busywe_pc",  32'(pc),       3);

        // write and start on the same edge from HALT: LDI 20 replaces LDI 5
        kick(1'b1, 4'd0, enc(1, 20));
        wait_halt(40, cyc);
        chk("samewe_out", 32'(out_data), 23);
        chk("samewe_pc",  32'(pc),       3);

`ifdef UP_CALL_STACK_EN
        fill_halt();
        prog[0] = enc(9, 4);
        prog[4] = enc(1, 7);
        prog[5] = enc(6, 0);
        prog[6] = enc(10, 0);
        load_prog();
        kick(1'b0, '0, '0);
        wait_halt(60, cyc);
        chk("call_out",    32'(out_data),  7);
        chk("call_pc",     32'(pc),        1);
        chk("call_halted", 32'(halted),    1);

        fill_halt();
        for (int i = 0; i < 5; i++) prog[i] = enc(9, i + 1);
        load_prog();
        kick(1'b0, '0, '0);
        wait_halt(60, cyc);
        chk("nest_pc",     32'(pc),        4);
        chk("nest_cycles", 32'(cyc),       10);

        fill_halt();
        prog[0] = enc(1, 1);
        prog[1] = enc(10, 0);
        load_prog();
        kick(1'b0, '0, '0);
        wait_halt(40, cyc);
        chk("ret_empty_pc", 32'(pc), 1);
`else
        fill_halt();
        prog[0] = enc(9, 4);
        prog[1] = enc(10, 0);
        prog[2] = enc(1, 8'h5A);
        prog[3] = enc(6, 0);
        prog[5] = enc(1, 8'h11);
        prog[6] = enc(6, 0);
        load_prog();
        kick(1'b0, '0, '0);
        wait_halt(40, cyc);
        chk("nostack_out", 32'(out_data), 8'h5A);
        chk("nostack_pc",  32'(pc),       4);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/up_seq_controller.md
UP_SEQ_CONTROLLER -- requirements
Module: up_seq_controller

Interface
REQ-001 Parameter DATA_W, default 8: accumulator and I/O width; SHALL be >= ADDR_W.
REQ-002 Parameter ADDR_W, default 4: program address width; DEPTH = 2^ADDR_W words.
REQ-003 Instruction word SHALL be 4+DATA_W bits: [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] operand.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 nRst  input  1  asynchronous, active-low reset.
REQ-006 prog_we  input  1  program-memory write strobe.
REQ-007 prog_addr  input  ADDR_W  program-memory write address.
REQ-008 prog_data  input  4+DATA_W  program-memory write data.
REQ-009 start  input  1  begin execution at address 0.
REQ-010 in_data  input  DATA_W  external input sampled by IN.
REQ-011 out_data  output  DATA_W  registered output written by OUT.
REQ-012 out_valid  output  1  one-cycle pulse when out_data updates.
REQ-013 busy  output  1  high in FETCH or EXEC.
REQ-014 halted  output  1  high in HALT.
REQ-015 pc  output  ADDR_W  current program counter.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, EXEC, HALT; each instruction takes exactly 2 cycles (FETCH latches word at pc, EXEC executes).
REQ-017 start in IDLE or HALT SHALL set pc=0, clear zero flag and go to FETCH; start in FETCH/EXEC SHALL be ignored.
REQ-018 prog_we SHALL write memory only in IDLE or HALT; ignored while busy.
REQ-019 Opcodes: 0 NOP, 1 LDI acc=opnd, 2 ADD acc+=opnd, 3 SUB acc-=opnd, 4 JMP pc=opnd, 5 JZ pc=opnd if zero, 6 OUT out_data=acc, 7 IN acc=in_data, 8 HALT; unlisted opcodes SHALL execute as NOP.
REQ-020 ADD/SUB SHALL wrap modulo 2^DATA_W; zero flag SHALL update on LDI, ADD, SUB, IN only.
REQ-021 Jump targets SHALL use operand[ADDR_W-1:0]; non-jump EXEC SHALL set pc=pc+1, wrapping DEPTH-1 to 0.
REQ-022 out_valid SHALL assert the cycle after OUT's EXEC for exactly one cycle.
REQ-023 HALT SHALL leave pc at the HALT address and hold acc/out_data until next start.
REQ-024 Simultaneous start and prog_we in IDLE/HALT: write SHALL complete and execution SHALL start, same edge.

Reset
REQ-025 nRst low SHALL immediately force IDLE, pc=0, acc=0, zero=0, out_data=0, out_valid=0, busy=0, halted=0, stack pointer=0, at any state including mid-instruction.
REQ-026 Program memory contents SHALL NOT be reset.

Configuration
REQ-027 Macro UP_CALL_STACK_EN SHALL compile in a 4-entry return stack with opcodes 9 CALL (push pc+1, pc=opnd) and 10 RET (pop to pc).
REQ-028 With the macro: CALL on full stack or RET on empty stack SHALL enter HALT without modifying pc or stack.
REQ-029 Without the macro: opcodes 9 and 10 SHALL execute as NOP and no stack storage SHALL exist.

Structure
REQ-030 Package up_pkg SHALL hold opcode constants, FSM state encoding and the stack depth constant.
REQ-031 Program memory SHALL be sub-module up_imem (synchronous write, combinational read, DEPTH x (4+DATA_W)).

Verification
REQ-032 Load {LDI 5, ADD 3, OUT, HALT}, start -> out_data=8 with one out_valid pulse, halted=1, pc=3, 8 cycles after start.
REQ-033 Load {LDI 2, SUB 1, JZ 4, JMP 1, OUT, HALT} -> exactly one out_valid with out_data=0.
REQ-034 LDI 250, ADD 10, OUT (DATA_W=8) -> out_data=4; zero flag 0.
REQ-035 nRst pulsed during EXEC of ADD -> all outputs 0, IDLE next cycle, memory intact; restart reproduces REQ-032.
REQ-036 prog_we during busy -> memory unchanged, program result unaffected.
REQ-037 With UP_CALL_STACK_EN: CALL 4 at 0, HALT at 1, {LDI 7, OUT, RET} at 4 -> out_data=7, halted with pc=1; five nested CALLs -> HALT on fifth.
